// File: rtl/adc_code_hist.sv
// adc_code_hist
//
// Histogram engine for the 3-bit ADC code stream. A start request clears
// the per-code bin counters and opens an acquisition window of WIN_LEN
// accepted samples. Once the window is full, the bin counts are streamed
// out, one record per bin in ascending order, over a valid/ready handshake.
//
// Ports
//   clk        system / sampling clock
//   rstn       asynchronous active-low reset
//   code       ADC code, qualified by code_valid
//   code_valid sample strobe, only counted during acquisition
//   start      acquisition request, level-sampled while idle
//   busy       acquisition or dump in progress
//   done       single-cycle pulse on the first idle cycle after a dump
//   out_valid  bin record presented (high for the whole dump)
//   out_ready  consumer accepts the current record
//   out_bin    bin index of the current record
//   out_count  count held for out_bin
//   out_last   current record is the final bin

module adc_code_hist #(
    parameter int CODE_W  = 3,
    parameter int CNT_W   = 16,
    parameter int WIN_LEN = 1024
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic [CODE_W-1:0] code,
    input  logic              code_valid,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CODE_W-1:0] out_bin,
    output logic [CNT_W-1:0]  out_count,
    output logic              out_last
);

    localparam int NBIN = 2 ** CODE_W;

    // Sample count held just before the window-closing sample is accepted.
    localparam logic [CNT_W-1:0] WIN_LAST = CNT_W'(WIN_LEN - 1);

    typedef enum logic [1:0] {
        IDLE,
        ACQ,
        DUMP
    } state_e;

    state_e                       state_q, state_d;
    logic [NBIN-1:0][CNT_W-1:0]   bin_q,   bin_d;
    logic [CNT_W-1:0]             samp_q,  samp_d;
    logic [CODE_W-1:0]            idx_q,   idx_d;
    logic                         done_q,  done_d;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
            bin_q   <= '0;
            samp_q  <= '0;
            idx_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            bin_q   <= bin_d;
            samp_q  <= samp_d;
            idx_q   <= idx_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        bin_d   = bin_q;
        samp_d  = samp_q;
        idx_d   = idx_q;
        done_d  = 1'b0;

        unique case (state_q)
            IDLE: begin
                // Bins survive the idle period; they are only cleared
                // when the next acquisition is requested.
                if (start) begin
                    bin_d   = '0;
                    samp_d  = '0;
                    idx_d   = '0;
                    state_d = ACQ;
                end
            end

            ACQ: begin
                if (code_valid) begin
                    // Saturate rather than wrap; only reachable when the
                    // window equals the full counter range.
                    if (bin_q[code] != '1) begin
                        bin_d[code] = bin_q[code] + CNT_W'(1);
                    end
                    samp_d = samp_q + CNT_W'(1);
                    if (samp_q == WIN_LAST) begin
                        state_d = DUMP;
                    end
                end
            end

            DUMP: begin
                if (out_ready) begin
                    // The index wraps back to 0 on the final transfer, so
                    // out_bin reads 0 again once idle.
                    idx_d = idx_q + CODE_W'(1);
                    if (idx_q == '1) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // All outputs decode registered state only; out_ready never reaches
    // out_valid combinationally.
    assign busy      = (state_q != IDLE);
    assign out_valid = (state_q == DUMP);
    assign out_bin   = idx_q;
    assign out_count = bin_q[idx_q];
    assign out_last  = (state_q == DUMP) && (idx_q == '1);
    assign done      = done_q;

endmodule

// File: tb/tb_adc_code_hist.sv
module tb_adc_code_hist;

    localparam int CODE_W = 3;
    localparam int CNT_W  = 16;
    localparam int NBIN   = 8;

    logic clk = 1'b0;
    logic rstn;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Expected bin counts, pushed in bin order as stimulus is driven.
    int exp_q[$];

    // Instance A: WIN_LEN = 16
    logic [CODE_W-1:0] code_a, bin_a;
    logic              cv_a, start_a, rdy_a, busy_a, done_a, ov_a, last_a;
    logic [CNT_W-1:0]  cnt_a;
    // Instance B: WIN_LEN = 1024
    logic [CODE_W-1:0] code_b, bin_b;
    logic              cv_b, start_b, rdy_b, busy_b, done_b, ov_b, last_b;
    logic [CNT_W-1:0]  cnt_b;
    // Instance C: WIN_LEN = 4
    logic [CODE_W-1:0] code_c, bin_c;
    logic              cv_c, start_c, rdy_c, busy_c, done_c, ov_c, last_c;
    logic [CNT_W-1:0]  cnt_c;

    adc_code_hist #(.CODE_W(CODE_W), .CNT_W(CNT_W), .WIN_LEN(16)) u_a (
        .clk(clk), .rstn(rstn), .code(code_a), .code_valid(cv_a), .start(start_a),
        .busy(busy_a), .done(done_a), .out_valid(ov_a), .out_ready(rdy_a),
        .out_bin(bin_a), .out_count(cnt_a), .out_last(last_a)
    );

    adc_code_hist #(.CODE_W(CODE_W), .CNT_W(CNT_W), .WIN_LEN(1024)) u_b (
        .clk(clk), .rstn(rstn), .code(code_b), .code_valid(cv_b), .start(start_b),
        .busy(busy_b), .done(done_b), .out_valid(ov_b), .out_ready(rdy_b),
        .out_bin(bin_b), .out_count(cnt_b), .out_last(last_b)
    );

    adc_code_hist #(.CODE_W(CODE_W), .CNT_W(CNT_W), .WIN_LEN(4)) u_c (
        .clk(clk), .rstn(rstn), .code(code_c), .code_valid(cv_c), .start(start_c),
        .busy(busy_c), .done(done_c), .out_valid(ov_c), .out_ready(rdy_c),
        .out_bin(bin_c), .out_count(cnt_c), .out_last(last_c)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Quantizer of the reference ADC: count of thresholds at or below v.
    function automatic logic [CODE_W-1:0] sine_code(int i);
        real v;
        int  c;
        v = 2.6 + 2.5 * $sin(2.0 * 3.14159265358979 * i / 100.0);
        c = 0;
        if (v >= 0.5) c++;
        if (v >= 1.1) c++;
        if (v >= 1.8) c++;
        if (v >= 2.5) c++;
        if (v >= 3.2) c++;
        if (v >= 4.0) c++;
        if (v >= 4.7) c++;
        return CODE_W'(c);
    endfunction

    task automatic test_reset();
        int m[NBIN];
        int n, cyc, e;
        logic lx;
        rstn = 1'b0;
        code_a = '0; cv_a = 0; start_a = 0; rdy_a = 1;
        code_b = '0; cv_b = 0; start_b = 0; rdy_b = 1;
        code_c = '0; cv_c = 0; start_c = 0; rdy_c = 1;
        #1;
        checks++; if ({busy_a, done_a, ov_a, last_a, bin_a, cnt_a} !== '0) begin failures++; $display("FAIL reset_init: got %h required 0", {busy_a, done_a, ov_a, last_a, bin_a, cnt_a}); end
        tick(); tick();
        rstn = 1'b1;
        tick();
        start_a = 1; tick(); start_a = 0;
        checks++; if (busy_a !== 1'b1) begin failures++; $display("FAIL reset_busy_acq: got %b required 1", busy_a); end
        for (int i = 0; i < 5; i++) begin
            code_a = 3'd1; cv_a = 1; tick();
        end
        cv_a = 0;
        #2 rstn = 1'b0;
        #1;
        checks++; if ({busy_a, done_a, ov_a, last_a, bin_a, cnt_a} !== '0) begin failures++; $display("FAIL reset_async: got %h required 0", {busy_a, done_a, ov_a, last_a, bin_a, cnt_a}); end
        tick();
        rstn = 1'b1;
        tick();
        foreach (m[b]) m[b] = 0;
        start_a = 1; tick(); start_a = 0;
        for (int i = 0; i < 16; i++) begin
            code_a = CODE_W'(i % 4); cv_a = 1; m[i % 4]++; tick();
        end
        cv_a = 0;
        for (int b = 0; b < NBIN; b++) exp_q.push_back(m[b]);
        n = 0; cyc = 0;
        while (n < NBIN && cyc < 50) begin
            if (ov_a === 1'b1) begin
                e = exp_q.pop_front();
                lx = (n == NBIN - 1);
                checks++; if (bin_a !== CODE_W'(n)) begin failures++; $display("FAIL reset_bin: got %0d required %0d", bin_a, n); end
                checks++; if (cnt_a !== CNT_W'(e)) begin failures++; $display("FAIL reset_count bin %0d: got %0d required %0d", n, cnt_a, e); end
                n++;
            end
            tick(); cyc++;
        end
        checks++; if (n != NBIN) begin failures++; $display("FAIL reset_dump_timeout: got %0d records required %0d", n, NBIN); end
        exp_q.delete();
    endtask

    task automatic test_ramp();
        int n, cyc, e;
        logic lx;
        rdy_a = 1;
        start_a = 1; tick(); start_a = 0;
        for (int i = 0; i < 16; i++) begin
            checks++; if (ov_a !== 1'b0 || busy_a !== 1'b1) begin failures++; $display("FAIL ramp_acq_state cycle %0d: got ov=%b busy=%b required ov=0 busy=1", i, ov_a, busy_a); end
            code_a = CODE_W'(i % 8); cv_a = 1; tick();
        end
        cv_a = 0;
        for (int b = 0; b < NBIN; b++) exp_q.push_back(2);
        checks++; if (ov_a !== 1'b1) begin failures++; $display("FAIL ramp_dump_entry: got %b required 1", ov_a); end
        n = 0; cyc = 0;
        while (n < NBIN && cyc < 50) begin
            checks++; if (done_a !== 1'b0) begin failures++; $display("FAIL ramp_done_early: got %b required 0", done_a); end
            if (ov_a === 1'b1) begin
                e = exp_q.pop_front();
                lx = (n == NBIN - 1);
                checks++; if (bin_a !== CODE_W'(n)) begin failures++; $display("FAIL ramp_bin: got %0d required %0d", bin_a, n); end
                checks++; if (cnt_a !== CNT_W'(e)) begin failures++; $display("FAIL ramp_count bin %0d: got %0d required %0d", n, cnt_a, e); end
                checks++; if (last_a !== lx) begin failures++; $display("FAIL ramp_last bin %0d: got %b required %b", n, last_a, lx); end
                n++;
            end
            tick(); cyc++;
        end
        checks++; if (n != NBIN || cyc != NBIN) begin failures++; $display("FAIL ramp_dump_len: got %0d records in %0d cycles required %0d in %0d", n, cyc, NBIN, NBIN); end
        checks++; if ({done_a, busy_a, ov_a} !== 3'b100) begin failures++; $display("FAIL ramp_done_cycle: got done/busy/valid=%b required 100", {done_a, busy_a, ov_a}); end
        tick();
        checks++; if (done_a !== 1'b0) begin failures++; $display("FAIL ramp_done_width: got %b required 0", done_a); end
    endtask

    task automatic test_backpressure();
        int n, cyc, e, held;
        int m[NBIN];
        foreach (m[b]) m[b] = 0;
        rdy_a = 1;
        start_a = 1; tick(); start_a = 0;
        for (int i = 0; i < 32; i++) begin
            checks++; if (ov_a !== 1'b0) begin failures++; $display("FAIL gap_acq_len cycle %0d: got valid=%b required 0", i, ov_a); end
            code_a = 3'd5; cv_a = (i % 2 == 1); if (i % 2 == 1) m[5]++; tick();
        end
        cv_a = 0;
        for (int b = 0; b < NBIN; b++) exp_q.push_back(m[b]);
        checks++; if (ov_a !== 1'b1) begin failures++; $display("FAIL gap_dump_entry: got %b required 1", ov_a); end
        n = 0; cyc = 0; held = 0;
        while (n < NBIN && cyc < 60) begin
            checks++; if (ov_a !== 1'b1) begin failures++; $display("FAIL gap_valid cycle %0d: got %b required 1", cyc, ov_a); end
            if (n == 2 && held < 3) begin
                rdy_a = 0;
                checks++; if (bin_a !== 3'd2 || cnt_a !== CNT_W'(exp_q[0])) begin failures++; $display("FAIL gap_hold %0d: got bin %0d count %0d required bin 2 count %0d", held, bin_a, cnt_a, exp_q[0]); end
                held++;
            end else begin
                rdy_a = 1;
                e = exp_q.pop_front();
                checks++; if (bin_a !== CODE_W'(n)) begin failures++; $display("FAIL gap_bin: got %0d required %0d", bin_a, n); end
                checks++; if (cnt_a !== CNT_W'(e)) begin failures++; $display("FAIL gap_count bin %0d: got %0d required %0d", n, cnt_a, e); end
                n++;
            end
            tick(); cyc++;
        end
        checks++; if (n != NBIN || cyc != NBIN + 3) begin failures++; $display("FAIL gap_dump_len: got %0d records in %0d cycles required %0d in %0d", n, cyc, NBIN, NBIN + 3); end
        checks++; if (done_a !== 1'b1) begin failures++; $display("FAIL gap_done: got %b required 1", done_a); end
        tick();
    endtask

    task automatic test_sine();
        int m[NBIN];
        int got[NBIN];
        int n, cyc, e, sum;
        logic [CODE_W-1:0] c;
        foreach (m[b]) m[b] = 0;
        rdy_b = 1;
        start_b = 1; tick(); start_b = 0;
        for (int i = 0; i < 1024; i++) begin
            c = sine_code(i);
            code_b = c; cv_b = 1; m[c]++;
            if (i == 1023) begin
                checks++; if ({busy_b, ov_b} !== 2'b10) begin failures++; $display("FAIL sine_acq_len: got busy/valid=%b required 10", {busy_b, ov_b}); end
            end
            tick();
        end
        cv_b = 0;
        for (int b = 0; b < NBIN; b++) exp_q.push_back(m[b]);
        n = 0; cyc = 0; sum = 0;
        while (n < NBIN && cyc < 50) begin
            if (ov_b === 1'b1) begin
                e = exp_q.pop_front();
                got[n] = int'(cnt_b);
                sum += int'(cnt_b);
                checks++; if (cnt_b !== CNT_W'(e)) begin failures++; $display("FAIL sine_count bin %0d: got %0d required %0d", n, cnt_b, e); end
                checks++; if (cnt_b == '0) begin failures++; $display("FAIL sine_missing_code bin %0d: got 0 required nonzero", n); end
                n++;
            end
            tick(); cyc++;
        end
        checks++; if (n != NBIN) begin failures++; $display("FAIL sine_dump_timeout: got %0d records required %0d", n, NBIN); end
        checks++; if (sum != 1024) begin failures++; $display("FAIL sine_sum: got %0d required 1024", sum); end
        checks++; if (!(got[0] > got[3] && got[7] > got[3])) begin failures++; $display("FAIL sine_density: got bin0=%0d bin7=%0d bin3=%0d required ends above bin3", got[0], got[7], got[3]); end
        tick();
    endtask

    task automatic test_ignore();
        int n, cyc, e;
        rdy_a = 1;
        start_a = 1; tick(); start_a = 0;
        for (int i = 0; i < 16; i++) begin
            code_a = CODE_W'(i % 8); cv_a = 1; start_a = (i == 8); tick();
        end
        for (int b = 0; b < NBIN; b++) exp_q.push_back(2);
        // Noise while dumping: start plus valid samples on the last bin.
        start_a = 1; cv_a = 1; code_a = 3'd7; rdy_a = 0;
        for (int i = 0; i < 3; i++) begin
            checks++; if (ov_a !== 1'b1 || bin_a !== 3'd0) begin failures++; $display("FAIL ign_dump_hold %0d: got valid=%b bin=%0d required 1 0", i, ov_a, bin_a); end
            tick();
        end
        start_a = 0; rdy_a = 1;
        n = 0; cyc = 0;
        while (n < NBIN && cyc < 50) begin
            if (ov_a === 1'b1) begin
                e = exp_q.pop_front();
                checks++; if (bin_a !== CODE_W'(n) || cnt_a !== CNT_W'(e)) begin failures++; $display("FAIL ign_record: got bin %0d count %0d required bin %0d count %0d", bin_a, cnt_a, n, e); end
                n++;
            end
            tick(); cyc++;
        end
        checks++; if (n != NBIN) begin failures++; $display("FAIL ign_dump_timeout: got %0d records required %0d", n, NBIN); end
        for (int i = 0; i < 4; i++) tick();
        checks++; if (busy_a !== 1'b0 || ov_a !== 1'b0) begin failures++; $display("FAIL ign_idle_valid: got busy=%b valid=%b required 0 0", busy_a, ov_a); end
        cv_a = 0;
    endtask

    task automatic test_back_to_back();
        int n, cyc, e, dones;
        logic prev_done;
        for (int w = 0; w < 3; w++)
            for (int b = 0; b < NBIN; b++) exp_q.push_back(b == 3 ? 4 : 0);
        code_c = 3'd3; cv_c = 1; rdy_c = 1; start_c = 1;
        n = 0; cyc = 0; dones = 0; prev_done = 0;
        while (n < 3 * NBIN && cyc < 200) begin
            if (prev_done) begin
                checks++; if (busy_c !== 1'b1) begin failures++; $display("FAIL b2b_new_acq: got busy=%b required 1", busy_c); end
            end
            prev_done = done_c;
            if (done_c === 1'b1) begin
                dones++;
                checks++; if (busy_c !== 1'b0) begin failures++; $display("FAIL b2b_done_busy: got %b required 0", busy_c); end
            end
            if (ov_c === 1'b1) begin
                e = exp_q.pop_front();
                checks++; if (bin_c !== CODE_W'(n % NBIN) || cnt_c !== CNT_W'(e)) begin failures++; $display("FAIL b2b_record %0d: got bin %0d count %0d required bin %0d count %0d", n, bin_c, cnt_c, n % NBIN, e); end
                n++;
            end
            tick(); cyc++;
        end
        checks++; if (n != 3 * NBIN) begin failures++; $display("FAIL b2b_timeout: got %0d records required %0d", n, 3 * NBIN); end
        checks++; if (dones != 2 || done_c !== 1'b1) begin failures++; $display("FAIL b2b_done_count: got %0d pulses plus final %b required 2 plus 1", dones, done_c); end
        start_c = 0; cv_c = 0;
        tick();
    endtask

    initial begin
        test_reset();
        test_ramp();
        test_backpressure();
        test_sine();
        test_ignore();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, failures so far %0d", failures);
        $fatal(1);
    end

endmodule
